// File: rtl/deci_pkg.sv
// Shared types and helpers for the binary-to-BCD display converter.
package deci_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/deci_disp_conv_add3_shift.sv
// One double-dabble BCD digit cell: add 3 when the digit is 5 or more, then shift left by one.
module deci_add3_shift (
    input  logic [3:0] din,
    input  logic       shift_in,
    output logic [3:0] dout,
    output logic       carry_out
);

    logic [3:0] adj;

    always_comb begin
        adj = (din >= 4'd5) ? din + 4'd3 : din;
    end

    assign {carry_out, dout} = {adj, shift_in};

endmodule

// File: rtl/deci_disp_conv.sv
// Sequential binary-to-BCD display converter, one bit per clock; displayed outputs hold until DONE.
// Optional DECI_BLANK_EN: leading zero digits are replaced by the blank code.
module deci_disp_conv
    import deci_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    value,
    input  logic                start,
    output logic [4*DIGITS-1:0] digits,
    output logic                negative,
    output logic                overflow,
    output logic                valid,
    output logic                busy,
    output logic                done
);

    localparam int CW = clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t          state;
    logic            pending;
    logic [WIDTH-1:0] last_val;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_in;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_next;
    logic [BW-1:0]   disp_next;
    logic [CW-1:0]   cnt;
    logic            sign_r;
    logic            sign_in;
    logic            ovf_r;
    logic [DIGITS:0] chain;

    assign sign_in = (SIGNED != 0) ? value[WIDTH-1] : 1'b0;
    // Negating the most negative value yields 2^(WIDTH-1), which still fits unsigned.
    assign mag_in  = sign_in ? -value : value;

    assign chain[0] = mag[WIDTH-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        deci_add3_shift u_cell (
            .din       (bcd[4*g +: 4]),
            .shift_in  (chain[g]),
            .dout      (bcd_next[4*g +: 4]),
            .carry_out (chain[g+1])
        );
    end

    always_comb begin
        disp_next = bcd;
        if (ovf_r) begin
            disp_next = {DIGITS{4'h9}};
        end
`ifdef DECI_BLANK_EN
        else begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (lead && (bcd[4*i +: 4] == 4'h0)) begin
                    disp_next[4*i +: 4] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= 1'b1;
            last_val <= '0;
            mag      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            ovf_r    <= 1'b0;
            digits   <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending || start || (value != last_val)) begin
                        last_val <= value;
                        mag      <= mag_in;
                        sign_r   <= sign_in;
                        bcd      <= '0;
                        ovf_r    <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        pending  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd   <= bcd_next;
                    mag   <= {mag[WIDTH-2:0], 1'b0};
                    // Any bit leaving the top digit means the magnitude does not fit.
                    ovf_r <= ovf_r | chain[DIGITS];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    digits   <= disp_next;
                    negative <= sign_r;
                    overflow <= ovf_r;
                    valid    <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deci_disp_conv.sv
// Scoreboard bench: a signed 3-digit and an unsigned 2-digit converter share the same stimulus.
module tb_deci_disp_conv;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] value;

    logic [11:0] digits_s;
    logic        neg_s, ovf_s, valid_s, busy_s, done_s;
    logic [7:0]  digits_u;
    logic        neg_u, ovf_u, valid_u, busy_u, done_u;

    typedef struct {
        logic [39:0] dig;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    exp_t es, eu;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    deci_disp_conv #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .digits(digits_s), .negative(neg_s), .overflow(ovf_s),
        .valid(valid_s), .busy(busy_s), .done(done_s)
    );

    deci_disp_conv #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .digits(digits_u), .negative(neg_u), .overflow(ovf_u),
        .valid(valid_u), .busy(busy_u), .done(done_u)
    );

    // Reference: decimal digits of the magnitude by plain division.
    function automatic exp_t model(input logic [7:0] v, input int nd, input bit sgn);
        exp_t   e;
        longint mag;
        longint lim;
        bit     lead;
        e.dig = '0;
        e.neg = sgn && v[7];
        mag   = e.neg ? (256 - longint'(v)) : longint'(v);
        lim   = 1;
        repeat (nd) lim = lim * 10;
        if (mag >= lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < nd; i++) e.dig[4*i +: 4] = 4'h9;
        end else begin
            e.ovf = 1'b0;
            for (int i = 0; i < nd; i++) begin
                e.dig[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
`ifdef DECI_BLANK_EN
            lead = 1'b1;
            for (int i = nd - 1; i > 0; i--) begin
                if (lead && e.dig[4*i +: 4] == 4'h0) e.dig[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`else
            lead = 1'b0;
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        q_s.push_back(model(v, 3, 1'b1));
        q_u.push_back(model(v, 2, 1'b0));
    endtask

    task automatic set_val(input logic [7:0] v);
        value = v;
        push(v);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits_s"}, 64'(digits_s), 64'h0);
        check({tag, "_neg_s"},    64'(neg_s),    64'h0);
        check({tag, "_ovf_s"},    64'(ovf_s),    64'h0);
        check({tag, "_valid_s"},  64'(valid_s),  64'h0);
        check({tag, "_busy_s"},   64'(busy_s),   64'h0);
        check({tag, "_done_s"},   64'(done_s),   64'h0);
        check({tag, "_digits_u"}, 64'(digits_u), 64'h0);
        check({tag, "_valid_u"},  64'(valid_u),  64'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && done_s) begin
            if (q_s.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL s_unexpected_done: got done with digits %0h, expected no done", digits_s);
            end else begin
                es = q_s.pop_front();
                check("s_digits", 64'(digits_s), 64'(es.dig[11:0]));
                check("s_negative", 64'(neg_s), 64'(es.neg));
                check("s_overflow", 64'(ovf_s), 64'(es.ovf));
                check("s_valid", 64'(valid_s), 64'h1);
                check("s_busy_with_done", 64'(busy_s), 64'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_u) begin
            if (q_u.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u_unexpected_done: got done with digits %0h, expected no done", digits_u);
            end else begin
                eu = q_u.pop_front();
                check("u_digits", 64'(digits_u), 64'(eu.dig[7:0]));
                check("u_negative", 64'(neg_u), 64'h0);
                check("u_overflow", 64'(ovf_u), 64'(eu.ovf));
                check("u_valid", 64'(valid_u), 64'h1);
            end
        end
    end

    initial begin
        logic [7:0] v;
        logic [7:0] dir [7];
        int         lat;
        int         budget;

        dir = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'd100, 8'd99, 8'd7};
        rst   = 1'b1;
        start = 1'b0;
        value = 8'h00;
        hold(3);
        check_reset_outputs("reset");
        push(8'h00);
        rst = 1'b0;
        hold(14);

        // Latency from the change (LOAD on the next edge) to the done pulse.
        set_val(dir[0]);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done_s && lat < 40);
        check("latency", 64'(lat), 64'd10);
        hold(4);

        for (int i = 1; i < 7; i++) begin
            set_val(dir[i]);
            hold(14);
        end

        // Change during SHIFT must still be converted afterwards.
        set_val(8'd5);
        hold(3);
        set_val(8'd42);
        hold(24);

        start = 1'b1;
        push(8'd42);
        @(negedge clk);
        start = 1'b0;
        hold(14);

        // start while busy is dropped: no extra done expected.
        set_val(8'd200);
        hold(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold(24);

        // Reset mid-conversion; the pending restart converts the same value.
        set_val(8'd150);
        hold(4);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        hold(14);

        for (int n = 0; n < 60; n++) begin
            do v = 8'($urandom); while (v == value);
            set_val(v);
            if ($urandom_range(0, 2) == 0) begin
                hold($urandom_range(1, 5));
                do v = 8'($urandom); while (v == value);
                set_val(v);
                hold(24 + $urandom_range(0, 4));
            end else begin
                hold(14 + $urandom_range(0, 6));
            end
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                push(value);
                @(negedge clk);
                start = 1'b0;
                hold(14);
            end
        end

        budget = 0;
        while ((q_s.size() != 0 || q_u.size() != 0) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("drain", 64'(q_s.size() + q_u.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
